bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
Shares the minx system bus between the s1c88 CPU and up to NUM_MASTERS DMA-style bus masters, such as the PRC and a future blitter or sound DMA.
- Requests a bus hold from the CPU through the bus_request/bus_ack handshake.
- Arbitrates among pending masters and grants the bus to one of them.
- Steers address, data, read, write and bus_status from the owner to the external bus.
- Sits in minx between the CPU and masters and the memory/register bus. It replaces the ad-hoc single-master mux.

Parameters:
NUM_MASTERS, 2, number of non-CPU bus masters (1..4).
ROUND_ROBIN, 1, 1 = rotating priority starting after the last owner; 0 = fixed priority, lowest index wins.
HANDOFF, 1, 1 = pass the bus straight to the next pending master without returning it to the CPU.
MAX_HOLD, 0, maximum GRANT cycles per ownership; 0 = unlimited.

Ports:
clk  in  1  system clock, all logic on posedge.
reset  in  1  asynchronous, active-high reset.
m_req  in  NUM_MASTERS  per-master bus request, level; held high while the master needs the bus.
m_grant  out  NUM_MASTERS  one-hot grant, registered.
m_address  in  NUM_MASTERS*24  per-master address, packed with master 0 in the LSBs.
m_data_out  in  NUM_MASTERS*8  per-master write data.
m_write  in  NUM_MASTERS  per-master write strobe.
m_read  in  NUM_MASTERS  per-master read strobe.
m_bus_status  in  NUM_MASTERS*2  per-master bus command.
cpu_address  in  24  CPU address.
cpu_data_out  in  8  CPU write data.
cpu_write  in  1  CPU write strobe.
cpu_read  in  1  CPU read strobe.
cpu_bus_status  in  2  CPU bus command.
cpu_bus_request  out  1  hold request to the CPU, registered.
cpu_bus_ack  in  1  CPU has released the bus; asserted at an instruction boundary.
address_out  out  24  muxed bus address.
data_out  out  8  muxed write data.
write  out  1  muxed write strobe.
read  out  1  muxed read strobe.
bus_status  out  2  muxed bus command.
bus_owner  out  3  0 = CPU; k+1 = master k.
preempt  out  1  one-cycle pulse when MAX_HOLD forces a grant off.

Behaviour:
- Reset values:
  - state = IDLE; m_grant = 0; cpu_bus_request = 0; bus_owner = 0; preempt = 0; hold counter = 0.
  - RR pointer = 0, so master 0 has highest priority first.
  - Reset asserted mid-grant drops everything immediately and returns ownership to the CPU.
- Mux rule: combinational, driven from the registered grant.
  - When m_grant[k] = 1, bus outputs come from master k.
  - Otherwise bus outputs come from the CPU, unchanged.
  - No cycle exists with two owners.
- FSM, all transitions on posedge clk:
  - IDLE: cpu_bus_request = 0. If |m_req, go to REQUEST and set cpu_bus_request = 1 next cycle.
  - REQUEST: hold cpu_bus_request = 1 and wait for cpu_bus_ack = 1.
    - On ack with |m_req: select the winner, set m_grant next cycle, go to GRANT.
    - On ack with m_req = 0 (request withdrawn): go to RELEASE.
    - With no ack, wait indefinitely; there is no timeout.
  - GRANT: the owner keeps the bus while m_req[owner] = 1. The hold counter increments each cycle.
    - When m_req[owner] drops: m_grant clears next cycle.
      - If HANDOFF = 1 and another request is pending: the new winner is granted one cycle later, with a one-cycle gap where the CPU-idle bus has outputs muxed to the CPU (the CPU is still held).
      - Otherwise go to RELEASE.
    - When MAX_HOLD != 0 and the counter reaches MAX_HOLD-1: pulse preempt, clear the grant, and treat it as a release.
      - The preempted master must drop its request within 1 cycle of the grant falling; a request held longer re-enters arbitration.
    - If cpu_bus_ack falls while in GRANT (protocol error): clear the grant at once, go to IDLE, set bus_owner = 0.
  - RELEASE: cpu_bus_request = 0. Wait for cpu_bus_ack = 0, then go to IDLE. New requests wait until IDLE.
- Arbitration:
  - Round-robin: search starts at (last_owner+1) mod NUM_MASTERS. The pointer updates only on grant.
  - Fixed priority: lowest index wins.
  - Simultaneous requests resolve in a single cycle.
- Latency: req high at cycle 0 → cpu_bus_request at 1 → ack at t → m_grant at t+1. This is the minimum with ack at cycle 1, giving grant at cycle 2.
- bus_owner tracks the registered grant.

Decomposition:
- Shared package minx_bus_pkg:
  - BUS_ADDR_W = 24, BUS_DATA_W = 8.
  - Bus command constants (MEM_READ, MEM_WRITE, IRQ_READ, NONE), shared with the CPU.
  - arb_state_t enum {IDLE, REQUEST, GRANT, RELEASE}.
- One sub-module, rr_picker: combinational round-robin/fixed one-hot selector with inputs req, ptr and mode.

Test Plan:
- Single master: m_req[0] rises at cycle 0, ack at cycle 3 → cpu_bus_request = 1 at cycle 1; m_grant = 01 at cycle 4; address_out = m_address[0] while granted; req falls → grant 0 next cycle, then request 0, then owner = CPU after ack falls.
- Simultaneous requests, ROUND_ROBIN = 1, HANDOFF = 1: m_req = 11 with owner history empty → master 0 granted; it drops → master 1 granted 2 cycles later without cpu_bus_request deasserting; the second round starts with master 1 after master 0.
- Fixed priority: m_req = 11 repeatedly → master 0 always wins; master 1 granted only when m_req[0] = 0.
- MAX_HOLD = 8 with m_req[0] held → preempt pulses at grant cycle 8; grant clears; master 1 pending is granted next.
- Withdrawn request: req pulses for 1 cycle, ack arrives later → no grant issued, RELEASE → IDLE; the bus is never muxed away from the CPU.
- Reset asserted asynchronously mid-GRANT → m_grant = 0, cpu_bus_request = 0, bus_owner = 0 immediately; after release, a normal request sequence works.

Source files
------------

// File: rtl/minx_bus_pkg.sv
// Shared minx bus definitions: bus widths, bus command codes and arbiter states.
package minx_bus_pkg;

  localparam int BUS_ADDR_W = 24;
  localparam int BUS_DATA_W = 8;

  // Bus command codes, common with the s1c88 core.
  localparam logic [1:0] NONE      = 2'd0;
  localparam logic [1:0] IRQ_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;
  localparam logic [1:0] MEM_READ  = 2'd3;

  typedef enum logic [1:0] {IDLE, REQUEST, GRANT, RELEASE} arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// One-hot request selector: rotating priority from ptr when mode = 1, lowest index when mode = 0.
module rr_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  gnt
);

  logic [PW-1:0] shamt;
  logic [N-1:0]  rot;
  logic [N-1:0]  lsb;

  // Rotate so ptr lands in bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    shamt = mode ? ptr : '0;
    rot   = N'({req, req} >> shamt);
    lsb   = rot & (~rot + N'(1));
    gnt   = N'(({lsb, lsb} << shamt) >> N);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the minx bus between the CPU and NUM_MASTERS DMA masters via a CPU hold handshake.
// Grant is registered; bus steering is combinational from the registered grant.
module bus_arbiter
  import minx_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ROUND_ROBIN = 1,
  parameter int HANDOFF     = 1,
  parameter int MAX_HOLD    = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_req,
  output logic [NUM_MASTERS-1:0]            m_grant,
  input  logic [NUM_MASTERS*BUS_ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS*BUS_DATA_W-1:0] m_data_out,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS-1:0]            m_read,
  input  logic [NUM_MASTERS*2-1:0]          m_bus_status,
  input  logic [BUS_ADDR_W-1:0]             cpu_address,
  input  logic [BUS_DATA_W-1:0]             cpu_data_out,
  input  logic                              cpu_write,
  input  logic                              cpu_read,
  input  logic [1:0]                        cpu_bus_status,
  output logic                              cpu_bus_request,
  input  logic                              cpu_bus_ack,
  output logic [BUS_ADDR_W-1:0]             address_out,
  output logic [BUS_DATA_W-1:0]             data_out,
  output logic                              write,
  output logic                              read,
  output logic [1:0]                        bus_status,
  output logic [2:0]                        bus_owner,
  output logic                              preempt
);

  localparam int PW = idx_w(NUM_MASTERS);
  localparam int CW = 16;

  arb_state_t             state;
  logic [NUM_MASTERS-1:0] pick;
  logic [PW-1:0]          pick_idx;
  logic [PW-1:0]          next_ptr;
  logic [PW-1:0]          rr_ptr;
  logic [CW-1:0]          hold_cnt;
  logic                   any_req;
  logic                   owner_req;
  logic                   others_pending;
  logic                   hold_expired;
  logic                   load_grant;

  rr_picker #(.N(NUM_MASTERS), .PW(PW)) u_picker (
    .req  (m_req),
    .ptr  (rr_ptr),
    .mode (ROUND_ROBIN != 0),
    .gnt  (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++)
      if (pick[k]) pick_idx = PW'(k);
  end

  assign next_ptr       = (pick_idx == PW'(NUM_MASTERS - 1)) ? '0 : pick_idx + PW'(1);
  assign any_req        = |m_req;
  assign owner_req      = |(m_req & m_grant);
  assign others_pending = |(m_req & ~m_grant);
  assign hold_expired   = (MAX_HOLD != 0) && (hold_cnt == CW'(MAX_HOLD - 1));
  // An empty grant while in GRANT is the one-cycle handoff gap.
  assign load_grant     = cpu_bus_ack && any_req &&
                          ((state == REQUEST) || (state == GRANT && m_grant == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      m_grant         <= '0;
      cpu_bus_request <= 1'b0;
      bus_owner       <= 3'd0;
      preempt         <= 1'b0;
      hold_cnt        <= '0;
      rr_ptr          <= '0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state           <= REQUEST;
            cpu_bus_request <= 1'b1;
          end
        end
        REQUEST: begin
          if (cpu_bus_ack && !any_req) begin
            state           <= RELEASE;
            cpu_bus_request <= 1'b0;
          end
        end
        GRANT: begin
          if (!cpu_bus_ack) begin
            state           <= IDLE;
            m_grant         <= '0;
            bus_owner       <= 3'd0;
            cpu_bus_request <= 1'b0;
          end else if (m_grant == '0) begin
            if (!any_req) begin
              state           <= RELEASE;
              cpu_bus_request <= 1'b0;
            end
          end else if (!owner_req || hold_expired) begin
            m_grant   <= '0;
            bus_owner <= 3'd0;
            preempt   <= owner_req;
            if (!(HANDOFF != 0 && others_pending)) begin
              state           <= RELEASE;
              cpu_bus_request <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (!cpu_bus_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (load_grant) begin
        state     <= GRANT;
        m_grant   <= pick;
        bus_owner <= 3'(pick_idx) + 3'd1;
        rr_ptr    <= next_ptr;
        hold_cnt  <= '0;
      end
    end
  end

  // Grant is one-hot, so at most one master overrides the CPU defaults.
  always_comb begin
    address_out = cpu_address;
    data_out    = cpu_data_out;
    write       = cpu_write;
    read        = cpu_read;
    bus_status  = cpu_bus_status;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (m_grant[k]) begin
        address_out = m_address[k*BUS_ADDR_W +: BUS_ADDR_W];
        data_out    = m_data_out[k*BUS_DATA_W +: BUS_DATA_W];
        write       = m_write[k];
        read        = m_read[k];
        bus_status  = m_bus_status[k*2 +: 2];
      end
    end
  end

endmodule
